// File: rtl/zdos_multi_if.sv
// ---------------------------------------------------------------------------
// zdos_multi_if
// Bus bundle between the Z80 bus decode / memory mapper and zdos_multi.
//
// Parameters:
//   DRV_W              width of the drive-select field (NDRV = 2**DRV_W)
//
// Signals:
//   zpos               Z80 strobe-position qualifier           (decode -> zdos)
//   m1_n               Z80 M1, active low                      (decode -> zdos)
//   vg_rdwr_fclk       one-cycle pulse on a VG93 port access   (decode -> zdos)
//   fdd_mask[NDRV]     per-drive emulation enable              (decode -> zdos)
//   vg_a[DRV_W]        currently selected drive                (decode -> zdos)
//   romnram            ROM (not RAM) mapped in the CPU window  (decode -> zdos)
//   dos                DOS ROM select                          (zdos -> mapper)
//   in_trdemu          emulation page mapped                   (zdos -> mapper)
//   trdemu_wr_disable  write-protect for the emulation page    (zdos -> mapper)
//
// Modports: master = bus decode / mapper side, slave = zdos_multi.
// ---------------------------------------------------------------------------
interface zdos_multi_if #(
    parameter int DRV_W = 2
);
    localparam int NDRV = 2 ** DRV_W;

    logic             zpos;
    logic             m1_n;
    logic             vg_rdwr_fclk;
    logic [NDRV-1:0]  fdd_mask;
    logic [DRV_W-1:0] vg_a;
    logic             romnram;
    logic             dos;
    logic             in_trdemu;
    logic             trdemu_wr_disable;

    modport master (
        output zpos, m1_n, vg_rdwr_fclk, fdd_mask, vg_a, romnram,
        input  dos, in_trdemu, trdemu_wr_disable
    );

    modport slave (
        input  zpos, m1_n, vg_rdwr_fclk, fdd_mask, vg_a, romnram,
        output dos, in_trdemu, trdemu_wr_disable
    );
endinterface

// File: rtl/zdos_multi.sv
// ---------------------------------------------------------------------------
// zdos_multi
// DOS/TR-DOS emulation control for the Z80 side. Drives the DOS ROM-mapping
// signal, traps VG93 register accesses on emulated drives into the emulation
// RAM page, remembers which drive caused the trap and counts trap entries.
//
// Optional feature (macro ZDOS_WDT_EN): a watchdog that forces exit from the
// emulation page if the NMI handler never releases it within WDT_LIMIT cycles.
// Without the macro no counter is built and wdt_fire is tied low.
//
// Ports:
//   fclk           system clock, all state changes on posedge
//   rst_n          asynchronous active-low reset
//   dos_turn_on    one-cycle request dos=1
//   dos_turn_off   one-cycle request dos=0 (beats dos_turn_on)
//   cpm_n          low forces dos=1 (beats both requests)
//   in_nmi         NMI mode active, blocks clr_nmi
//   clr_nmi        one-cycle pulse releasing the emulation page
//   trap_clr       one-cycle pulse zeroing trap_cnt
//   bus            zdos_multi_if.slave (Z80 decode inputs, mapper outputs)
//   trap_drv       drive number latched at trap entry
//   trap_cnt       saturating count of trap entries
//   wdt_fire       one-cycle pulse on watchdog forced exit
// ---------------------------------------------------------------------------
module zdos_multi #(
    parameter int                DRV_W     = 2,
    parameter logic              DOS_RST   = 1'b1,
    parameter int                TCNT_W    = 8,
    parameter int                WDT_W     = 16,
    parameter logic [WDT_W-1:0]  WDT_LIMIT = 16'hFFFF
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              dos_turn_on,
    input  logic              dos_turn_off,
    input  logic              cpm_n,
    input  logic              in_nmi,
    input  logic              clr_nmi,
    input  logic              trap_clr,
    zdos_multi_if.slave       bus,
    output logic [DRV_W-1:0]  trap_drv,
    output logic [TCNT_W-1:0] trap_cnt,
    output logic              wdt_fire
);

    typedef enum logic {
        IDLE = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam logic [TCNT_W-1:0] TCNT_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

    state_t state_q;
    state_t state_d;
    logic   dos_q;
    logic   wr_dis_q;
    logic   trap_on;
    logic   clr_ok;
    logic   enter;

    // A trap needs an access to an emulated drive while the DOS ROM is in
    // the window; dos here is the registered value seen by the CPU.
    assign trap_on = bus.vg_rdwr_fclk & bus.fdd_mask[bus.vg_a] & dos_q & bus.romnram;
    assign clr_ok  = clr_nmi & ~in_nmi;

    assign bus.dos               = dos_q;
    assign bus.in_trdemu         = (state_q == TRAP);
    assign bus.trdemu_wr_disable = wr_dis_q;

`ifdef ZDOS_WDT_EN
    localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_exit;
`endif

    // Next-state logic. A valid clear in the same cycle as a trap request
    // keeps us in IDLE; in TRAP a valid clear always takes precedence over
    // the watchdog so a coinciding limit does not produce wdt_fire.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
`ifdef ZDOS_WDT_EN
        wdt_exit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (trap_on && !clr_ok) begin
                    state_d = TRAP;
                    enter   = 1'b1;
                end
            end
            TRAP: begin
                if (clr_ok) begin
                    state_d = IDLE;
`ifdef ZDOS_WDT_EN
                end else if (!trap_on && (wdt_cnt == WDT_LIMIT)) begin
                    state_d  = IDLE;
                    wdt_exit = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DOS ROM select: cpm_n low wins, then off, then on.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            dos_q <= DOS_RST;
        end else if (!cpm_n) begin
            dos_q <= 1'b1;
        end else if (dos_turn_off) begin
            dos_q <= 1'b0;
        end else if (dos_turn_on) begin
            dos_q <= 1'b1;
        end
    end

    // Write protect is released by an M1 fetch and re-armed by any trap
    // request regardless of FSM state; the release wins.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_dis_q <= 1'b0;
        end else if (bus.zpos && !bus.m1_n) begin
            wr_dis_q <= 1'b0;
        end else if (trap_on) begin
            wr_dis_q <= 1'b1;
        end
    end

    // Trap bookkeeping happens only on the IDLE->TRAP transition.
    // trap_clr coinciding with an entry leaves exactly that entry counted.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            trap_drv <= '0;
            trap_cnt <= '0;
        end else begin
            if (enter) begin
                trap_drv <= bus.vg_a;
            end
            if (trap_clr) begin
                trap_cnt <= enter ? TCNT_ONE : '0;
            end else if (enter && (trap_cnt != '1)) begin
                trap_cnt <= trap_cnt + TCNT_ONE;
            end
        end
    end

`ifdef ZDOS_WDT_EN
    // Watchdog runs only while in TRAP and staying there; any further trap
    // request re-arms it so active emulation keeps the page mapped.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt  <= '0;
            wdt_fire <= 1'b0;
        end else begin
            wdt_fire <= wdt_exit;
            if (state_q != TRAP || state_d != TRAP || trap_on) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + WDT_ONE;
            end
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_zdos_multi.sv
// ---------------------------------------------------------------------------
// tb_zdos_multi
// Self-checking bench for zdos_multi (DRV_W=2, TCNT_W=2, WDT_LIMIT=10).
// Directed sequences followed by randomized cycles; every cycle all outputs
// are compared against a cycle-level reference model held in the bench.
// Compile with ZDOS_WDT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_zdos_multi;

    localparam int DRV_W     = 2;
    localparam int TCNT_W    = 2;
    localparam int WDT_W     = 16;
    localparam int WDT_LIMIT = 10;
    localparam int TCNT_MAX  = 3;

    logic fclk;
    logic rst_n;
    logic dos_turn_on;
    logic dos_turn_off;
    logic cpm_n;
    logic in_nmi;
    logic clr_nmi;
    logic trap_clr;
    logic [DRV_W-1:0]  trap_drv;
    logic [TCNT_W-1:0] trap_cnt;
    logic              wdt_fire;

    zdos_multi_if #(.DRV_W(DRV_W)) bus ();

    zdos_multi #(
        .DRV_W    (DRV_W),
        .DOS_RST  (1'b1),
        .TCNT_W   (TCNT_W),
        .WDT_W    (WDT_W),
        .WDT_LIMIT(16'(WDT_LIMIT))
    ) dut (
        .fclk        (fclk),
        .rst_n       (rst_n),
        .dos_turn_on (dos_turn_on),
        .dos_turn_off(dos_turn_off),
        .cpm_n       (cpm_n),
        .in_nmi      (in_nmi),
        .clr_nmi     (clr_nmi),
        .trap_clr    (trap_clr),
        .bus         (bus),
        .trap_drv    (trap_drv),
        .trap_cnt    (trap_cnt),
        .wdt_fire    (wdt_fire)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state, plain integers
    int m_dos, m_trap, m_wr, m_drv, m_cnt, m_wdt, m_fire;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic model_reset();
        m_dos  = 1;
        m_trap = 0;
        m_wr   = 0;
        m_drv  = 0;
        m_cnt  = 0;
        m_wdt  = 0;
        m_fire = 0;
    endtask

    // One clock of the model from the inputs present before the edge.
    task automatic model_step();
        int trap_req, clr_valid, entry;
        int n_dos, n_trap, n_wr, n_wdt;
        trap_req  = (bus.vg_rdwr_fclk && bus.fdd_mask[bus.vg_a] && m_dos != 0 && bus.romnram) ? 1 : 0;
        clr_valid = (clr_nmi && !in_nmi) ? 1 : 0;
        entry     = (m_trap == 0 && trap_req == 1 && clr_valid == 0) ? 1 : 0;

        n_dos = !cpm_n ? 1 : (dos_turn_off ? 0 : (dos_turn_on ? 1 : m_dos));
        n_wr  = (bus.zpos && !bus.m1_n) ? 0 : (trap_req == 1 ? 1 : m_wr);

        n_trap = m_trap;
        n_wdt  = 0;
        m_fire = 0;
        if (m_trap == 0) begin
            n_trap = entry;
        end else if (clr_valid == 1) begin
            n_trap = 0;
        end else if (trap_req == 1) begin
            n_wdt = 0;
        end else begin
`ifdef ZDOS_WDT_EN
            if (m_wdt == WDT_LIMIT) begin
                n_trap = 0;
                m_fire = 1;
            end else begin
                n_wdt = m_wdt + 1;
            end
`endif
        end

        if (trap_clr) m_cnt = entry;
        else if (entry == 1) m_cnt = (m_cnt + 1 > TCNT_MAX) ? TCNT_MAX : m_cnt + 1;
        if (entry == 1) m_drv = int'(bus.vg_a);

        m_dos  = n_dos;
        m_wr   = n_wr;
        m_trap = n_trap;
        m_wdt  = n_wdt;
    endtask

    task automatic check_all();
        checkOutput("dos",       32'(bus.dos),               32'(m_dos));
        checkOutput("in_trdemu", 32'(bus.in_trdemu),         32'(m_trap));
        checkOutput("wr_dis",    32'(bus.trdemu_wr_disable), 32'(m_wr));
        checkOutput("trap_drv",  32'(trap_drv),              32'(m_drv));
        checkOutput("trap_cnt",  32'(trap_cnt),              32'(m_cnt));
        checkOutput("wdt_fire",  32'(wdt_fire),              32'(m_fire));
    endtask

    // Apply the currently driven inputs for one clock and check the result.
    task automatic applyStimulus();
        @(posedge fclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_pulses();
        dos_turn_on      = 1'b0;
        dos_turn_off     = 1'b0;
        clr_nmi          = 1'b0;
        trap_clr         = 1'b0;
        bus.vg_rdwr_fclk = 1'b0;
        bus.zpos         = 1'b0;
        bus.m1_n         = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        cpm_n       = 1'b1;
        in_nmi      = 1'b0;
        bus.fdd_mask = 4'b0100;
        bus.vg_a     = 2'd0;
        bus.romnram  = 1'b1;
        clear_pulses();
        model_reset();
        #12;
        check_all();
        #10;
        rst_n = 1'b1;

        // dos control
        applyStimulus();
        checkOutput("dos_after_reset", 32'(bus.dos), 32'd1);
        dos_turn_on = 1'b1; dos_turn_off = 1'b1;
        applyStimulus();
        checkOutput("dos_off_beats_on", 32'(bus.dos), 32'd0);
        clear_pulses();
        cpm_n = 1'b0;
        applyStimulus();
        checkOutput("dos_cpm_force", 32'(bus.dos), 32'd1);
        cpm_n = 1'b1;

        // Trap on drive 2
        bus.vg_a = 2'd2; bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        checkOutput("trap_enter", 32'(bus.in_trdemu), 32'd1);
        checkOutput("trap_wrdis", 32'(bus.trdemu_wr_disable), 32'd1);
        checkOutput("trap_drv2",  32'(trap_drv), 32'd2);
        checkOutput("trap_cnt1",  32'(trap_cnt), 32'd1);
        clear_pulses();

        // clr_nmi blocked by in_nmi, then accepted
        in_nmi = 1'b1; clr_nmi = 1'b1;
        applyStimulus();
        checkOutput("clr_blocked", 32'(bus.in_trdemu), 32'd1);
        in_nmi = 1'b0;
        applyStimulus();
        checkOutput("clr_exit", 32'(bus.in_trdemu), 32'd0);
        clear_pulses();

        // Unmasked drive does not trap
        bus.vg_a = 2'd1; bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        checkOutput("no_trap_drv1", 32'(bus.in_trdemu), 32'd0);
        clear_pulses();

        // Trap and clear together from IDLE: stay idle
        bus.vg_a = 2'd2; bus.vg_rdwr_fclk = 1'b1; clr_nmi = 1'b1;
        applyStimulus();
        checkOutput("trap_clr_same", 32'(bus.in_trdemu), 32'd0);
        checkOutput("cnt_unchanged", 32'(trap_cnt), 32'd1);
        bus.zpos = 1'b1; bus.m1_n = 1'b0;
        applyStimulus();
        checkOutput("wrdis_clear_wins", 32'(bus.trdemu_wr_disable), 32'd0);
        clear_pulses();

        // Saturation after five entries
        for (int i = 0; i < 5; i++) begin
            bus.vg_rdwr_fclk = 1'b1;
            applyStimulus();
            clear_pulses();
            clr_nmi = 1'b1;
            applyStimulus();
            clear_pulses();
        end
        checkOutput("cnt_saturate", 32'(trap_cnt), 32'd3);
        trap_clr = 1'b1; bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        checkOutput("cnt_clr_entry", 32'(trap_cnt), 32'd1);
        clear_pulses();

        // Watchdog: entered on previous edge, counter is 0
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("wdt_before_limit", 32'(bus.in_trdemu), 32'd1);
        applyStimulus();
`ifdef ZDOS_WDT_EN
        checkOutput("wdt_exit", 32'(bus.in_trdemu), 32'd0);
        checkOutput("wdt_fire_pulse", 32'(wdt_fire), 32'd1);
        applyStimulus();
        checkOutput("wdt_fire_once", 32'(wdt_fire), 32'd0);
        // Re-arm at count 5 delays the exit by 6 cycles
        bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        clear_pulses();
        for (int i = 0; i < 5; i++) applyStimulus();
        bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        clear_pulses();
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("wdt_rearm_hold", 32'(bus.in_trdemu), 32'd1);
        applyStimulus();
        checkOutput("wdt_rearm_exit", 32'(bus.in_trdemu), 32'd0);
        checkOutput("wdt_rearm_fire", 32'(wdt_fire), 32'd1);
`else
        for (int i = 0; i < 30; i++) applyStimulus();
        checkOutput("no_wdt_stay", 32'(bus.in_trdemu), 32'd1);
        checkOutput("no_wdt_fire", 32'(wdt_fire), 32'd0);
        clr_nmi = 1'b1;
        applyStimulus();
        clear_pulses();
`endif

        // Asynchronous reset in the middle of TRAP
        bus.vg_rdwr_fclk = 1'b1;
        applyStimulus();
        clear_pulses();
        checkOutput("pre_reset_trap", 32'(bus.in_trdemu), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cpm_n            = ($urandom_range(0, 15) != 0);
            dos_turn_off     = ($urandom_range(0, 15) == 0);
            dos_turn_on      = ($urandom_range(0, 3) == 0);
            in_nmi           = $urandom_range(0, 1) == 1;
            clr_nmi          = ($urandom_range(0, 7) == 0);
            trap_clr         = ($urandom_range(0, 15) == 0);
            bus.vg_rdwr_fclk = ($urandom_range(0, 5) == 0);
            bus.fdd_mask     = 4'($urandom);
            bus.vg_a         = 2'($urandom);
            bus.romnram      = ($urandom_range(0, 7) != 0);
            bus.zpos         = $urandom_range(0, 1) == 1;
            bus.m1_n         = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/zdos_multi.md
Name: zdos_multi

Overview:
- Next-generation DOS/TR-DOS emulation control for the Z80 side.
- Generates the DOS ROM-mapping signal.
- Traps VG93 register accesses for a parametrised number of drives into the emulation RAM page (#FE). Latches which drive caused the trap and counts traps.
- Optional watchdog forces exit from emulation if the NMI handler never releases it.
- Sits between the Z80 bus decode (vg_rdwr_fclk, zpos/m1_n) and the memory mapper (dos, in_trdemu, trdemu_wr_disable).

Parameters:
- DRV_W, 2, width of the drive-select field; number of drives NDRV = 2**DRV_W.
- DOS_RST, 1'b1, reset value of dos.
- TCNT_W, 8, width of the saturating trap counter.
- WDT_W, 16, watchdog counter width (used only with ZDOS_WDT_EN).
- WDT_LIMIT, 16'hFFFF, watchdog terminal count in fclk cycles (used only with ZDOS_WDT_EN).

Ports:
- fclk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- dos_turn_on  in  1  one-cycle request: dos=1.
- dos_turn_off  in  1  one-cycle request: dos=0.
- cpm_n  in  1  low forces dos=1.
- zpos  in  1  Z80 strobe-position qualifier.
- m1_n  in  1  Z80 M1, active low.
- in_nmi  in  1  NMI mode active; blocks exit from emulation.
- clr_nmi  in  1  one-cycle pulse on out (#BE),a.
- vg_rdwr_fclk  in  1  one-cycle pulse on a VG93 port access.
- fdd_mask  in  NDRV  per-drive emulation enable.
- vg_a  in  DRV_W  currently selected drive.
- romnram  in  1  ROM (not RAM) mapped in the CPU window.
- trap_clr  in  1  one-cycle pulse: zero trap_cnt.
- dos  out  1  DOS ROM select.
- in_trdemu  out  1  emulation page mapped.
- trdemu_wr_disable  out  1  write-protect for the emulation page.
- trap_drv  out  DRV_W  drive number latched at trap entry.
- trap_cnt  out  TCNT_W  saturating count of trap entries.
- wdt_fire  out  1  one-cycle pulse on watchdog forced exit.

Behaviour:
- Reset values: dos=DOS_RST, in_trdemu=0, trdemu_wr_disable=0, trap_drv=0, trap_cnt=0, wdt_fire=0, FSM=IDLE, watchdog counter=0. All outputs are registered.
- trap_on (combinational) = vg_rdwr_fclk & fdd_mask[vg_a] & dos & romnram.
- dos priority, one cycle after the inputs:
  - !cpm_n: dos=1.
  - else dos_turn_off: dos=0.
  - else dos_turn_on: dos=1.
  - Off beats on when both are asserted.
- FSM states: IDLE, TRAP. in_trdemu = (state==TRAP), registered.
- IDLE -> TRAP when trap_on and not (clr_nmi & !in_nmi). A simultaneous valid clear wins, and the FSM stays in IDLE.
- On entering TRAP:
  - trap_drv <= vg_a.
  - trap_cnt increments, saturating at all-ones.
  - watchdog counter cleared.
- TRAP -> IDLE when clr_nmi & !in_nmi. While in_nmi=1, clr_nmi is ignored and the FSM stays in TRAP.
- trap_on while already in TRAP:
  - No state change.
  - trap_drv and trap_cnt are unchanged.
  - Watchdog counter re-arms to 0.
- trdemu_wr_disable priority:
  - Cleared when zpos & !m1_n.
  - Else set when trap_on, independent of FSM state.
  - Clear wins when both occur in the same cycle.
- trap_cnt:
  - trap_clr zeroes it.
  - If trap_clr coincides with a trap entry, the result is 1.
- Latency: every output changes exactly one fclk edge after its qualifying input cycle.
- Asynchronous reset mid-TRAP returns everything to reset values immediately. No exit pulse is generated.

Optional Feature:
- Macro: ZDOS_WDT_EN.
- Defined:
  - In TRAP, the watchdog counter increments every fclk.
  - When it equals WDT_LIMIT and no clr/trap_on arrives that cycle, the FSM goes to IDLE, the counter clears and wdt_fire pulses for 1 cycle.
  - A forced exit overrides in_nmi.
  - trdemu_wr_disable is untouched.
  - A valid clr_nmi in the same cycle as the limit exits normally, with no wdt_fire.
- Undefined: no counter logic is built, wdt_fire is tied 0, and TRAP is left only by clr_nmi & !in_nmi.

Test Plan:
- Reset, then cpm_n=1 -> dos=1, in_trdemu=0, trap_cnt=0. Pulse dos_turn_off together with dos_turn_on -> dos=0 next edge. Drop cpm_n -> dos=1.
- DRV_W=2, fdd_mask=4'b0100, dos=1, romnram=1, vg_a=2, pulse vg_rdwr_fclk -> next edge in_trdemu=1, trdemu_wr_disable=1, trap_drv=2, trap_cnt=1. Repeat with vg_a=1 -> no trap.
- In TRAP with in_nmi=1, pulse clr_nmi -> in_trdemu stays 1. With in_nmi=0, pulse clr_nmi -> in_trdemu=0 next edge.
- Same cycle trap_on and clr_nmi (in_nmi=0) from IDLE -> in_trdemu stays 0, trap_cnt unchanged. zpos=1 with m1_n=0 and trap_on together -> trdemu_wr_disable=0.
- TCNT_W=2: 5 trap entry/exit cycles -> trap_cnt=3. trap_clr coinciding with a 6th entry -> trap_cnt=1.
- ZDOS_WDT_EN, WDT_LIMIT=10: enter TRAP, no clr -> wdt_fire pulse and in_trdemu=0 after 11 edges. A vg access at count 5 delays the exit by 6 cycles. Macro undefined -> stays in TRAP indefinitely.
